// File: rtl/gpzda_sender.sv
// gpzda_sender
// Serialises one NMEA ZDA sentence ("$GPZDA,hhmmss.cc,dd,mm,yyyy,,*CS"),
// presenting one ASCII byte at a time on a data/load stream with ready
// backpressure. The XOR checksum is built while the bytes go out.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       request one sentence (only looked at while idle)
//   hour_bcd, minute_bcd, second_bcd, centi_bcd, day_bcd, month_bcd
//               two BCD digits each, high nibble = tens
//   year_bcd    four BCD digits, [15:12] = thousands
//   ready       sink accepts the current byte this cycle
//   data        current ASCII byte (8'h00 when load is low)
//   load        data valid
//   busy        sentence in progress
//   done        one-cycle pulse after the last byte was accepted
//   error       one-cycle pulse when start was refused for a nibble > 9
module gpzda_sender #(
   parameter int B           = 8,
   parameter bit APPEND_CRLF = 1'b0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   hour_bcd,
   input  logic [7:0]   minute_bcd,
   input  logic [7:0]   second_bcd,
   input  logic [7:0]   centi_bcd,
   input  logic [7:0]   day_bcd,
   input  logic [7:0]   month_bcd,
   input  logic [15:0]  year_bcd,
   input  logic         ready,
   output logic [B-1:0] data,
   output logic         load,
   output logic         busy,
   output logic         done,
   output logic         error
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [5:0] LAST_IDX = APPEND_CRLF ? 6'd33 : 6'd31;

   state_t      state;
   state_t      state_next;
   logic [5:0]  idx;
   logic [7:0]  csum;
   logic [63:0] fields;
   logic [63:0] fields_in;
   logic        fields_ok;
   logic        error_q;
   logic [7:0]  byte_cur;

   // Upper-case hex digit for a checksum nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // ASCII digit for captured nibble k, counted from the hour tens digit.
   function automatic logic [7:0] nib_ascii(input logic [63:0] f, input int k);
      return 8'h30 + {4'h0, f[63-4*k -: 4]};
   endfunction

   assign fields_in = {hour_bcd, minute_bcd, second_bcd, centi_bcd,
                       day_bcd, month_bcd, year_bcd};

   // A start is only honoured when every one of the 16 nibbles is a decimal digit.
   always_comb begin
      fields_ok = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (fields_in[4*k +: 4] > 4'd9) fields_ok = 1'b0;
      end
   end

   // Byte map: fixed punctuation, digits from the captured fields, then the
   // checksum. By index 30 the accumulator already holds bytes 1..28.
   always_comb begin
      byte_cur = 8'h00;
      case (idx)
         6'd0:  byte_cur = 8'h24;
         6'd1:  byte_cur = 8'h47;
         6'd2:  byte_cur = 8'h50;
         6'd3:  byte_cur = 8'h5A;
         6'd4:  byte_cur = 8'h44;
         6'd5:  byte_cur = 8'h41;
         6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd28:
                byte_cur = 8'h2C;
         6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12:
                byte_cur = nib_ascii(fields, int'(idx) - 7);
         6'd13: byte_cur = 8'h2E;
         6'd14, 6'd15:
                byte_cur = nib_ascii(fields, int'(idx) - 8);
         6'd17, 6'd18:
                byte_cur = nib_ascii(fields, int'(idx) - 9);
         6'd20, 6'd21:
                byte_cur = nib_ascii(fields, int'(idx) - 10);
         6'd23, 6'd24, 6'd25, 6'd26:
                byte_cur = nib_ascii(fields, int'(idx) - 11);
         6'd29: byte_cur = 8'h2A;
         6'd30: byte_cur = hex_ascii(csum[7:4]);
         6'd31: byte_cur = hex_ascii(csum[3:0]);
         6'd32: byte_cur = 8'h0D;
         6'd33: byte_cur = 8'h0A;
         default: byte_cur = 8'h00;
      endcase
   end

   // State register plus the datapath registers. Fields are captured only
   // on an accepted start, so anything on the inputs during SEND is ignored.
   // The index and checksum only move on a transfer (load is implied by SEND).
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         csum    <= '0;
         fields  <= '0;
         error_q <= 1'b0;
      end else begin
         state   <= state_next;
         error_q <= (state == IDLE) && start && !fields_ok;
         case (state)
            IDLE: begin
               if (start && fields_ok) begin
                  fields <= fields_in;
                  idx    <= '0;
                  csum   <= '0;
               end
            end
            SEND: begin
               if (ready) begin
                  idx <= idx + 6'd1;
                  if (idx >= 6'd1 && idx <= 6'd28) csum <= csum ^ byte_cur;
               end
            end
            default: begin
               idx  <= '0;
               csum <= '0;
            end
         endcase
      end
   end

   // Next-state and output decode. DONE always lasts exactly one cycle and
   // does not look at start.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      data       = '0;
      error      = error_q;
      case (state)
         IDLE: begin
            if (start && fields_ok) state_next = SEND;
         end
         SEND: begin
            load = 1'b1;
            busy = 1'b1;
            data = byte_cur;
            if (ready && idx == LAST_IDX) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
